// File: rtl/audio_tdm_tx_pkg.sv
// Shared definitions for the serial audio transmitter: framing mode codes,
// transmitter state encoding, frame-size helper and parameter legality check.
package audio_pkg;

  // Framing mode codes, sampled on mode_i at each frame load.
  localparam logic AUD_MODE_I2S = 1'b0;
  localparam logic AUD_MODE_LJ  = 1'b1;

  // Transmitter activity: idle until enable is first seen, then running.
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } txState_e;

  // Number of sclk periods in one complete frame.
  function automatic int frameBits(input int channels, input int slotW);
    return channels * slotW;
  endfunction

  // Legal parameter combinations: 8..32 bit samples that fit in their slot,
  // an even channel count of 2..8 and a prescale input at least one bit wide.
  function automatic bit paramsLegal(input int sampleW, input int slotW,
                                     input int channels, input int prescaleW);
    return (sampleW >= 8) && (sampleW <= 32) && (slotW >= sampleW) &&
           (channels >= 2) && (channels <= 8) && ((channels % 2) == 0) &&
           (prescaleW >= 1);
  endfunction

endpackage

// File: rtl/audio_tdm_tx_if.sv
// Frame handshake between the audio mixer (master) and the transmitter (slave).
// One transfer carries a whole frame; channel 0 sits in the LSB field.
interface audio_tdm_tx_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/audio_tdm_tx_bclk_gen.sv
// Bit clock generator: a phase counter running 0..P that toggles sclk on every
// wrap, giving an sclk period of 2*(P+1) clk. fall_tick_o is high for the one
// clk cycle whose active edge takes sclk from high to low, so the parent can
// advance its bit counter on exactly the same edge the bit clock falls.
module audio_bclk_gen #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  run_i,
  input  logic                  restart_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  sclk_o,
  output logic                  fall_tick_o
);

  logic [PRESCALE_W-1:0] phaseCnt_q, phaseCnt_d;
  logic                  sclk_q, sclk_d;
  logic                  phaseWrap;

  assign phaseWrap   = run_i && !restart_i && (phaseCnt_q == prescale_i);
  assign fall_tick_o = phaseWrap && sclk_q;
  assign sclk_o      = sclk_q;

  // Next phase/sclk: hold at zero while stopped or restarting, else count and toggle on wrap.
  always_comb begin
    phaseCnt_d = phaseCnt_q;
    sclk_d     = sclk_q;
    if (!run_i || restart_i) begin
      phaseCnt_d = '0;
      sclk_d     = 1'b0;
    end else if (phaseWrap) begin
      phaseCnt_d = '0;
      sclk_d     = !sclk_q;
    end else begin
      phaseCnt_d = phaseCnt_q + PRESCALE_W'(1);
    end
  end

  // Phase counter and bit clock registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phaseCnt_q <= '0;
      sclk_q     <= 1'b0;
    end else begin
      phaseCnt_q <= phaseCnt_d;
      sclk_q     <= sclk_d;
    end
  end

endmodule

// File: rtl/audio_tdm_tx.sv
// Parametrised I2S / left-justified / TDM serial audio transmitter. Whole
// frames arrive through a one-deep holding buffer; at every frame boundary the
// buffer (or, on underrun, the last frame or silence) is moved into a shift
// register that is clocked out MSB first on the falling edges of sclk.
module audio_tdm_tx #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 16,
  parameter int CHANNELS      = 2,
  parameter int PRESCALE_W    = 8,
  parameter int UNDERRUN_MUTE = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  audio_tdm_tx_if.slave         s_if,
  output logic                  sclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  frame_start_o,
  output logic                  underrun_o,
  output logic [7:0]            underrun_cnt_o
);

  import audio_pkg::*;

  localparam int DATA_W = CHANNELS * SAMPLE_W;
  localparam int FB     = frameBits(CHANNELS, SLOT_W);
  localparam int IDX_W  = $clog2(FB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(FB / 2);

  if (!paramsLegal(SAMPLE_W, SLOT_W, CHANNELS, PRESCALE_W)) begin : gBadParams
    $error("audio_tdm_tx: illegal SAMPLE_W/SLOT_W/CHANNELS/PRESCALE_W combination");
  end

  txState_e              state_q;
  logic [DATA_W-1:0]     holdBuf_q;
  logic                  holdFull_q;
  logic [DATA_W-1:0]     lastFrame_q;
  logic [FB-1:0]         shiftReg_q;
  logic [IDX_W-1:0]      bitIdx_q;
  logic                  modeLatch_q;
  logic [PRESCALE_W-1:0] prescaleLatch_q;
  logic                  lrclk_q;
  logic                  sdata_q;
  logic                  frameStart_q;
  logic                  underrun_q;
  logic [7:0]            underrunCnt_q;

  logic                  accept;
  logic                  startLoad;
  logic                  wrapLoad;
  logic                  frameLoad;
  logic                  fallTick;
  logic [IDX_W-1:0]      bitIdxNext;
  logic [FB-1:0]         holdStream;
  logic [FB-1:0]         lastStream;
  logic [FB-1:0]         loadStream;

  assign s_if.s_ready = !holdFull_q;
  assign accept       = s_if.s_valid && !holdFull_q;

  // A frame loads either on the first cycle enable is seen, or when the last
  // bit of the current frame ends on an sclk falling edge.
  assign startLoad  = en_i && (state_q == TX_IDLE);
  assign wrapLoad   = en_i && fallTick && (bitIdx_q == LAST_IDX);
  assign frameLoad  = startLoad || wrapLoad;
  assign bitIdxNext = bitIdx_q + IDX_W'(1);

  audio_bclk_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) uBclkGen (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .run_i       (en_i),
    .restart_i   (startLoad),
    .prescale_i  (prescaleLatch_q),
    .sclk_o      (sclk_o),
    .fall_tick_o (fallTick)
  );

  // Lay the sample fields out as a serial stream: stream bit 0 (channel 0 MSB)
  // at the top of the vector, each slot padded with zeros below the sample.
  always_comb begin
    holdStream = '0;
    lastStream = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      holdStream[FB-1-c*SLOT_W -: SAMPLE_W] = holdBuf_q[c*SAMPLE_W +: SAMPLE_W];
      lastStream[FB-1-c*SLOT_W -: SAMPLE_W] = lastFrame_q[c*SAMPLE_W +: SAMPLE_W];
    end
    if (holdFull_q) begin
      loadStream = holdStream;
    end else if (UNDERRUN_MUTE != 0) begin
      loadStream = '0;
    end else begin
      loadStream = lastStream;
    end
  end

  // Holding buffer, frame loading, serialisation and all registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= TX_IDLE;
      holdBuf_q       <= '0;
      holdFull_q      <= 1'b0;
      lastFrame_q     <= '0;
      shiftReg_q      <= '0;
      bitIdx_q        <= '0;
      modeLatch_q     <= AUD_MODE_I2S;
      prescaleLatch_q <= '0;
      lrclk_q         <= 1'b0;
      sdata_q         <= 1'b0;
      frameStart_q    <= 1'b0;
      underrun_q      <= 1'b0;
      underrunCnt_q   <= '0;
    end else begin
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;

      if (accept) begin
        holdBuf_q  <= s_if.s_data;
        holdFull_q <= 1'b1;
      end else if (frameLoad && holdFull_q) begin
        holdFull_q <= 1'b0;
      end

      if (!en_i) begin
        state_q  <= TX_IDLE;
        bitIdx_q <= '0;
        lrclk_q  <= 1'b0;
        sdata_q  <= 1'b0;
      end else if (frameLoad) begin
        state_q         <= TX_RUN;
        bitIdx_q        <= '0;
        lrclk_q         <= 1'b0;
        modeLatch_q     <= mode_i;
        prescaleLatch_q <= prescale_i;
        shiftReg_q      <= loadStream;
        frameStart_q    <= 1'b1;
        if (holdFull_q) begin
          lastFrame_q <= holdBuf_q;
        end else begin
          underrun_q <= 1'b1;
          if (underrunCnt_q != 8'hFF) begin
            underrunCnt_q <= underrunCnt_q + 8'd1;
          end
        end
        // I2S bit 0 repeats the previous frame's final bit (zero after idle).
        if (mode_i == AUD_MODE_LJ) begin
          sdata_q <= loadStream[FB-1];
        end else if (state_q == TX_RUN) begin
          sdata_q <= shiftReg_q[FB-1];
        end else begin
          sdata_q <= 1'b0;
        end
      end else if (fallTick) begin
        bitIdx_q   <= bitIdxNext;
        lrclk_q    <= (bitIdxNext >= HALF_IDX);
        shiftReg_q <= shiftReg_q << 1;
        if (modeLatch_q == AUD_MODE_LJ) begin
          sdata_q <= shiftReg_q[FB-2];
        end else begin
          sdata_q <= shiftReg_q[FB-1];
        end
      end
    end
  end

  assign lrclk_o        = lrclk_q;
  assign sdata_o        = sdata_q;
  assign frame_start_o  = frameStart_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = underrunCnt_q;

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Self-checking bench for audio_tdm_tx: a stereo 16-bit instance with frame
// repeat on underrun, and a 4-slot TDM 12-in-16 instance with muting.
module tb_audio_tdm_tx;

  import audio_pkg::*;

  logic       clk;
  logic       resetN;
  logic       en;
  logic       mode;
  logic [7:0] prescale;
  logic       selB;

  logic       sclkA, lrclkA, sdataA, frameStartA, underrunA;
  logic [7:0] cntA;
  logic       sclkB, lrclkB, sdataB, frameStartB, underrunB;
  logic [7:0] cntB;

  int testsRun;
  int testsFailed;

  audio_tdm_tx_if #(.DATA_W(32)) ifA ();
  audio_tdm_tx_if #(.DATA_W(48)) ifB ();

  audio_tdm_tx uDutA (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .en_i           (en),
    .mode_i         (mode),
    .prescale_i     (prescale),
    .s_if           (ifA.slave),
    .sclk_o         (sclkA),
    .lrclk_o        (lrclkA),
    .sdata_o        (sdataA),
    .frame_start_o  (frameStartA),
    .underrun_o     (underrunA),
    .underrun_cnt_o (cntA)
  );

  audio_tdm_tx #(
    .SAMPLE_W      (12),
    .SLOT_W        (16),
    .CHANNELS      (4),
    .PRESCALE_W    (8),
    .UNDERRUN_MUTE (1)
  ) uDutB (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .en_i           (en),
    .mode_i         (mode),
    .prescale_i     (prescale),
    .s_if           (ifB.slave),
    .sclk_o         (sclkB),
    .lrclk_o        (lrclkB),
    .sdata_o        (sdataB),
    .frame_start_o  (frameStartB),
    .underrun_o     (underrunB),
    .underrun_cnt_o (cntB)
  );

  logic selSclk, selLrclk, selSdata, selFrameStart, selUnderrun, selReady;
  assign selSclk       = selB ? sclkB       : sclkA;
  assign selLrclk      = selB ? lrclkB      : lrclkA;
  assign selSdata      = selB ? sdataB      : sdataA;
  assign selFrameStart = selB ? frameStartB : frameStartA;
  assign selUnderrun   = selB ? underrunB   : underrunA;
  assign selReady      = selB ? ifB.s_ready : ifA.s_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        useB;
    logic        modeV;
    logic [7:0]  pre;
    logic [63:0] frame;
    int          nbits;
    logic [63:0] expData;
    logic [63:0] expLr;
    int          expPeriod;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic failNow(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: bounded wait expired", name);
  endtask

  task automatic pushFrame(input logic toB, input logic [63:0] frame);
    int guard;
    guard = 0;
    @(negedge clk);
    while (((toB ? ifB.s_ready : ifA.s_ready) !== 1'b1) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) failNow("push_ready");
    if (toB) begin
      ifB.s_data  = frame[47:0];
      ifB.s_valid = 1'b1;
    end else begin
      ifA.s_data  = frame[31:0];
      ifA.s_valid = 1'b1;
    end
    @(negedge clk);
    ifA.s_valid = 1'b0;
    ifB.s_valid = 1'b0;
  endtask

  task automatic captureFrame(input int nbits, output logic [63:0] dataBits, output logic [63:0] lrBits,
                              output int periodFirst, output int periodLast, output int extraStarts,
                              output logic urAtStart, output logic readyAtStart);
    int   guard;
    int   cyc;
    int   k;
    int   lastRise;
    logic prevSclk;
    dataBits = '0; lrBits = '0; periodFirst = 0; periodLast = 0;
    extraStarts = 0; urAtStart = 1'b0; readyAtStart = 1'b0;
    guard = 0;
    while (selFrameStart !== 1'b1 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      failNow("frame_start_wait");
      return;
    end
    urAtStart    = selUnderrun;
    readyAtStart = selReady;
    prevSclk = selSclk;
    cyc = 0; k = 0; lastRise = 0;
    while (k < nbits && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (selFrameStart === 1'b1) extraStarts++;
      if (prevSclk === 1'b0 && selSclk === 1'b1) begin
        dataBits[nbits-1-k] = selSdata;
        lrBits[nbits-1-k]   = selLrclk;
        if (k >= 1) begin
          periodLast = cyc - lastRise;
          if (k == 1) periodFirst = periodLast;
        end
        lastRise = cyc;
        k++;
      end
      prevSclk = selSclk;
    end
    if (k < nbits) failNow("capture_bits");
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [63:0] d, lr;
    int          pf, pl, xs;
    logic        ur, rdy;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    mode     = v.modeV;
    prescale = v.pre;
    selB     = v.useB;
    pushFrame(v.useB, v.frame);
    en = 1'b1;
    captureFrame(v.nbits, d, lr, pf, pl, xs, ur, rdy);
    checkOutput($sformatf("vec%0d_data", idx), d, v.expData);
    checkOutput($sformatf("vec%0d_lrclk", idx), lr, v.expLr);
    checkOutput($sformatf("vec%0d_period", idx), 64'(pf), 64'(v.expPeriod));
    checkOutput($sformatf("vec%0d_period_end", idx), 64'(pl), 64'(v.expPeriod));
    checkOutput($sformatf("vec%0d_single_start", idx), 64'(xs), 64'd0);
    checkOutput($sformatf("vec%0d_no_underrun", idx), 64'(ur), 64'd0);
    checkOutput($sformatf("vec%0d_ready_back", idx), 64'(rdy), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] d, lr;
    int          pf, pl, xs, urCount;
    logic        ur, rdy;

    testsRun = 0; testsFailed = 0;
    resetN = 1'b0; en = 1'b0; mode = AUD_MODE_I2S; prescale = 8'd3; selB = 1'b0;
    ifA.s_data = '0; ifA.s_valid = 1'b0;
    ifB.s_data = '0; ifB.s_valid = 1'b0;

    vecs[0] = '{1'b0, AUD_MODE_I2S, 8'd3, 64'h8001A5A5, 32, 64'h52D2C000, 64'h0000FFFF, 8};
    vecs[1] = '{1'b0, AUD_MODE_LJ,  8'd3, 64'h8001A5A5, 32, 64'hA5A58001, 64'h0000FFFF, 8};
    vecs[2] = '{1'b0, AUD_MODE_LJ,  8'd0, 64'h12345678, 32, 64'h56781234, 64'h0000FFFF, 2};
    vecs[3] = '{1'b0, AUD_MODE_I2S, 8'd1, 64'h0000FFFF, 32, 64'h7FFF8000, 64'h0000FFFF, 4};
    vecs[4] = '{1'b1, AUD_MODE_LJ,  8'd1, 64'hABC789456123, 64, 64'h123045607890ABC0, 64'h00000000FFFFFFFF, 4};
    vecs[5] = '{1'b1, AUD_MODE_I2S, 8'd0, 64'hABC789456123, 64, 64'h091822B03C4855E0, 64'h00000000FFFFFFFF, 2};

    // Reset values.
    #2;
    checkOutput("rst_sclk", 64'(sclkA), 64'd0);
    checkOutput("rst_lrclk", 64'(lrclkA), 64'd0);
    checkOutput("rst_sdata", 64'(sdataA), 64'd0);
    checkOutput("rst_frame_start", 64'(frameStartA), 64'd0);
    checkOutput("rst_underrun", 64'(underrunA), 64'd0);
    checkOutput("rst_cnt", 64'(cntA), 64'd0);
    checkOutput("rst_ready", 64'(ifA.s_ready), 64'd1);
    @(negedge clk);
    resetN = 1'b1;

    // Framing, mode, prescale and TDM layout.
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Muted underrun on the TDM instance directly after its last frame.
    captureFrame(64, d, lr, pf, pl, xs, ur, rdy);
    checkOutput("mute_data", d, 64'd0);
    checkOutput("mute_underrun", 64'(ur), 64'd1);

    // Prescale change mid-frame takes effect at the next frame.
    @(negedge clk);
    en = 1'b0; selB = 1'b0; mode = AUD_MODE_LJ; prescale = 8'd3;
    repeat (3) @(negedge clk);
    pushFrame(1'b0, 64'h8001A5A5);
    en = 1'b1;
    fork
      begin
        repeat (40) @(posedge clk);
        #2 prescale = 8'd0;
      end
    join_none
    captureFrame(32, d, lr, pf, pl, xs, ur, rdy);
    checkOutput("pre_old_first", 64'(pf), 64'd8);
    checkOutput("pre_old_last", 64'(pl), 64'd8);
    captureFrame(32, d, lr, pf, pl, xs, ur, rdy);
    checkOutput("pre_new_period", 64'(pf), 64'd2);
    checkOutput("pre_new_repeat", d, 64'hA5A58001);

    // Asynchronous reset mid-slot with a buffered frame and a nonzero count.
    pushFrame(1'b0, 64'h12345678);
    checkOutput("pre_rst_ready", 64'(ifA.s_ready), 64'd0);
    #1 resetN = 1'b0;
    #1;
    checkOutput("midrst_sclk", 64'(sclkA), 64'd0);
    checkOutput("midrst_lrclk", 64'(lrclkA), 64'd0);
    checkOutput("midrst_sdata", 64'(sdataA), 64'd0);
    checkOutput("midrst_cnt", 64'(cntA), 64'd0);
    checkOutput("midrst_ready", 64'(ifA.s_ready), 64'd1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    resetN = 1'b1;

    // Underrun: one real frame then three repeated frames.
    mode = AUD_MODE_LJ; prescale = 8'd0;
    repeat (2) @(negedge clk);
    pushFrame(1'b0, 64'h8001A5A5);
    en = 1'b1;
    captureFrame(32, d, lr, pf, pl, xs, ur, rdy);
    checkOutput("ur_first_data", d, 64'hA5A58001);
    checkOutput("ur_first_flag", 64'(ur), 64'd0);
    urCount = 0;
    for (int f = 0; f < 3; f++) begin
      captureFrame(32, d, lr, pf, pl, xs, ur, rdy);
      checkOutput($sformatf("ur_repeat%0d_data", f), d, 64'hA5A58001);
      if (ur === 1'b1) urCount++;
    end
    en = 1'b0;
    @(posedge clk); #1;
    checkOutput("ur_pulses", 64'(urCount), 64'd3);
    checkOutput("ur_cnt", 64'(cntA), 64'd3);

    // Enable low mid-frame with a frame waiting in the buffer.
    @(negedge clk);
    prescale = 8'd3;
    en = 1'b1;
    repeat (30) @(negedge clk);
    pushFrame(1'b0, 64'h12345678);
    en = 1'b0;
    @(posedge clk); #1;
    checkOutput("enlow_sclk", 64'(sclkA), 64'd0);
    checkOutput("enlow_lrclk", 64'(lrclkA), 64'd0);
    checkOutput("enlow_sdata", 64'(sdataA), 64'd0);
    checkOutput("enlow_ready", 64'(ifA.s_ready), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("enlow_ready_held", 64'(ifA.s_ready), 64'd0);
    en = 1'b1;
    @(posedge clk); #1;
    checkOutput("reen_frame_start", 64'(frameStartA), 64'd1);
    checkOutput("reen_underrun", 64'(underrunA), 64'd0);
    checkOutput("reen_ready", 64'(ifA.s_ready), 64'd1);
    captureFrame(32, d, lr, pf, pl, xs, ur, rdy);
    checkOutput("reen_data", d, 64'h56781234);
    checkOutput("reen_period", 64'(pf), 64'd8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
